// File: rtl/game_over_pkg.sv
// Shared types and default parameters for the game-over controller.
package game_over_pkg;
    typedef enum logic [1:0] {PLAY, HOLD, WAIT, REARM} go_state_e;

    localparam int unsigned GO_N_CH_DEF        = 2;
    localparam int unsigned GO_HOLD_CYCLES_DEF = 1024;
    localparam int unsigned GO_CNT_W_DEF       = 8;
endpackage

// File: rtl/first_set_enc.sv
// Lowest-index set-bit encoder with any-set and more-than-one-set flags.
module first_set_enc #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o,
    output logic             multi_o
);
    always_comb begin
        idx_o = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

    assign valid_o = |vec_i;
    assign multi_o = |(vec_i & (vec_i - 1'b1));
endmodule

// File: rtl/game_over_ctrl.sv
// Game-over controller: latches the first round-ending event, holds `over` for a
// minimum time, waits for restart, and re-arms once all sources are quiet.
module game_over_ctrl
    import game_over_pkg::*;
#(
    parameter int unsigned N_CH        = GO_N_CH_DEF,
    parameter int unsigned HOLD_CYCLES = GO_HOLD_CYCLES_DEF,
    parameter int unsigned CNT_W       = GO_CNT_W_DEF,
    parameter int unsigned ID_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       gameover_i,
    input  logic                  restart_i,
    output logic                  over_o,
    output logic                  over_pulse_o,
    output logic                  restart_ack_o,
    output logic [ID_W-1:0]       winner_id_o,
    output logic                  tie_o,
    output logic [N_CH-1:0]       hit_mask_o,
    output logic [CNT_W-1:0]      rounds_o,
    output logic [N_CH*CNT_W-1:0] wins_o
);
    go_state_e                      state_q;
    logic                           over_q, over_pulse_q, restart_ack_q, tie_q;
    logic [ID_W-1:0]                winner_id_q;
    logic [N_CH-1:0]                hit_mask_q;
    logic [CNT_W-1:0]               rounds_q;
    logic [N_CH-1:0][CNT_W-1:0]     wins_q;

    logic [ID_W-1:0] enc_idx;
    logic            enc_valid, enc_multi;
    logic            hold_done;

    first_set_enc #(.N(N_CH), .IDX_W(ID_W)) u_enc (
        .vec_i   (gameover_i),
        .idx_o   (enc_idx),
        .valid_o (enc_valid),
        .multi_o (enc_multi)
    );

    // Hold counter exists only when a minimum display time is requested.
    if (HOLD_CYCLES > 0) begin : g_hold
        localparam int unsigned HC_W = $clog2(HOLD_CYCLES + 1);
        logic [HC_W-1:0] hold_q, hold_d;

        assign hold_done = (hold_q == HC_W'(HOLD_CYCLES - 1));
        assign hold_d    = (state_q != HOLD || hold_done) ? '0 : hold_q + 1'b1;

        always_ff @(posedge clk) begin
            if (rst) hold_q <= '0;
            else     hold_q <= hold_d;
        end
    end else begin : g_no_hold
        assign hold_done = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PLAY;
            over_q        <= 1'b0;
            over_pulse_q  <= 1'b0;
            restart_ack_q <= 1'b0;
            tie_q         <= 1'b0;
            winner_id_q   <= '0;
            hit_mask_q    <= '0;
            rounds_q      <= '0;
            wins_q        <= '0;
        end else begin
            over_pulse_q  <= 1'b0;
            restart_ack_q <= 1'b0;
            case (state_q)
                PLAY: begin
                    // Restart in the same cycle as a round end suppresses the capture.
                    if (enc_valid && !restart_i) begin
                        hit_mask_q   <= gameover_i;
                        winner_id_q  <= enc_idx;
                        tie_q        <= enc_multi;
                        over_q       <= 1'b1;
                        over_pulse_q <= 1'b1;
                        if (rounds_q != '1) rounds_q <= rounds_q + 1'b1;
                        if (!enc_multi && wins_q[enc_idx] != '1)
                            wins_q[enc_idx] <= wins_q[enc_idx] + 1'b1;
                        state_q <= (HOLD_CYCLES == 0) ? WAIT : HOLD;
                    end
                end
                HOLD: begin
                    if (hold_done) state_q <= WAIT;
                end
                WAIT: begin
                    if (restart_i) begin
                        restart_ack_q <= 1'b1;
                        over_q        <= 1'b0;
                        state_q       <= REARM;
                    end
                end
                REARM: begin
                    if (!enc_valid) state_q <= PLAY;
                end
                default: state_q <= PLAY;
            endcase
        end
    end

    assign over_o        = over_q;
    assign over_pulse_o  = over_pulse_q;
    assign restart_ack_o = restart_ack_q;
    assign winner_id_o   = winner_id_q;
    assign tie_o         = tie_q;
    assign hit_mask_o    = hit_mask_q;
    assign rounds_o      = rounds_q;
    assign wins_o        = wins_q;
endmodule

// File: doc/game_over_ctrl.md
# game_over_ctrl

Parametrised game-over controller for N independent end-of-round sources (players, traps, timers). It latches the first round-ending event, identifies the triggering channel, and holds `over` for a guaranteed minimum display time. It then waits for a restart request and re-arms only after all sources have deasserted. It also keeps per-channel win counters and a round counter for the score overlay. The block sits between the game-logic modules and the draw/overlay path, replacing the fixed 2-bit latch.

## Interface
Parameters:
- `N_CH`, 2, number of game-over source channels (≥1)
- `HOLD_CYCLES`, 1024, minimum cycles `over` stays high before restart is accepted (0 = no hold)
- `CNT_W`, 8, width of round and win counters
- Derived constant: `ID_W` = max(1, $clog2(N_CH))

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `gameover`  in  N_CH  per-channel round-end request, level
- `restart`  in  1  restart request, level or pulse
- `over`  out  1  game-over state, registered
- `over_pulse`  out  1  one-cycle strobe on entry to game-over
- `restart_ack`  out  1  one-cycle strobe when restart is accepted
- `winner_id`  out  ID_W  lowest-index channel set at capture
- `tie`  out  1  more than one channel was set at capture
- `hit_mask`  out  N_CH  snapshot of `gameover` at capture
- `rounds`  out  CNT_W  completed-round count, saturating
- `wins`  out  N_CH*CNT_W  per-channel win counts; channel i occupies bits [i*CNT_W +: CNT_W]; saturating

## Operation
- FSM states: PLAY, HOLD, WAIT, REARM.
- **PLAY** (over=0):
  - If `gameover`≠0 and `restart`=0, then:
    - capture `hit_mask`, `winner_id` (lowest set index), and `tie` (popcount>1);
    - `rounds`++;
    - `wins[winner_id]`++ unless `tie`=1;
    - pulse `over_pulse`;
    - go to HOLD, or to WAIT if HOLD_CYCLES=0.
  - If `restart`=1 in the same cycle as `gameover`, restart dominates: no capture, stay in PLAY.
- **HOLD** (over=1):
  - The hold counter counts 0..HOLD_CYCLES-1, then the FSM goes to WAIT.
  - `restart` and `gameover` are ignored.
- **WAIT** (over=1):
  - On `restart`=1: pulse `restart_ack`, drop `over`, go to REARM.
- **REARM** (over=0):
  - Stay while `gameover`≠0.
  - Go to PLAY on the first cycle with `gameover`=0.
  - A source held high across a restart therefore never re-triggers.
- Captured fields (`winner_id`, `tie`, `hit_mask`) hold their values until the next capture. They are not cleared by restart.
- Counters saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Every output is registered. No output has a combinational path from an input.
- Reset values:
  - state = PLAY;
  - `over`, `over_pulse`, `restart_ack`, `tie` = 0;
  - `winner_id`, `hit_mask`, `rounds`, `wins` = 0;
  - hold counter = 0.
- Capture latency: `gameover` sampled high at edge k → `over`=1 and `over_pulse`=1 after edge k. `over_pulse` is low after edge k+1.
- `over` stays high for at least HOLD_CYCLES+1 cycles. For a restart held high continuously, the first accepted restart edge is edge k+HOLD_CYCLES+1.
- Restart sampled high in WAIT at edge m → `over`=0 and `restart_ack`=1 after edge m. The earliest new capture is at edge m+2, and only if `gameover`=0 at edge m+1.
- Reset mid-operation (any state) → PLAY next edge. All counters and captures are cleared.

## Structure
- `game_over_pkg`:
  - `typedef enum logic [1:0] {PLAY, HOLD, WAIT, REARM} go_state_e`
  - default parameter constants
- Sub-module `first_set_enc` (parameter `N`): combinational lowest-index encoder plus multi-hot flag. Inputs: N-bit vector. Outputs: index, valid, multi.
- The hold-counter width is $clog2(HOLD_CYCLES+1). It is guarded so that HOLD_CYCLES=0 compiles with no counter.

## Test plan
- N_CH=2, HOLD_CYCLES=4: pulse `gameover`=2'b10 one cycle → over=1 next cycle, over_pulse for 1 cycle, winner_id=1, tie=0, rounds=1, wins[1]=1.
- HOLD_CYCLES=4, hold `restart`=1 from the capture edge on → restart_ack exactly 5 cycles after capture; over=0 the same cycle; restart during HOLD has no effect.
- `gameover`=2'b11 → winner_id=0, tie=1, hit_mask=2'b11, rounds++, both wins unchanged.
- `gameover` and `restart` high on the same PLAY edge → no capture, over stays 0, rounds unchanged.
- Keep `gameover`=2'b01 high through restart → FSM sits in REARM with over=0. Drop `gameover`, raise it 1 cycle later → new capture, rounds=2.
- CNT_W=2: run 5 rounds won by channel 0 → rounds=3 and wins[0]=3 (saturated). Assert `rst` during HOLD → all outputs 0 next cycle.
